// File: rtl/cpu_thread_pkg.sv
// Shared thread-ID types, mode constants and the wrap-around helper
// used by the multithreaded front-end schedulers.
package cpu_thread_pkg;

    localparam int MAX_THREADS = 16;
    localparam int MAX_TID_W   = $clog2(MAX_THREADS);

    localparam int MODE_RR     = 0;
    localparam int MODE_BARREL = 1;

    // Widest thread ID; narrower instances cast to their own TID_W.
    typedef logic [MAX_TID_W-1:0] tid_t;

    // Successor of a thread ID in a ring of num_threads entries. The wrap is
    // explicit because num_threads need not be a power of two.
    function automatic tid_t tid_wrap_inc(input tid_t cur, input int num_threads);
        if (int'(cur) + 1 == num_threads) begin
            return '0;
        end
        return cur + tid_t'(1);
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Circular priority select: first asserted request at or after start,
// wrapping past the top index. Purely combinational.
module rr_prio_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   grant,
    output logic               found
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_win;
    logic [IDX_W:0]       offset;
    logic [IDX_W:0]       idx_sum;

    // Rotating the doubled vector puts request 'start' at bit 0.
    assign req_dbl = {req, req};
    assign req_win = NUM_REQ'(req_dbl >> start);

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_win[i]) begin
                found  = 1'b1;
                offset = (IDX_W + 1)'(i);
            end
        end
    end

    always_comb begin
        idx_sum = {1'b0, start} + offset;
        if (idx_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
        end
        grant = idx_sum[IDX_W-1:0];
    end

endmodule

// File: rtl/thread_scheduler_rr.sv
// Per-cycle thread selector for fetch: round-robin with ready-skip (MODE 0)
// or strict barrel rotation (MODE 1). All outputs are registered.
module thread_scheduler_rr
    import cpu_thread_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = $clog2(NUM_THREADS),
    parameter int MODE        = MODE_RR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [NUM_THREADS-1:0] thread_ready,
    output logic [TID_W-1:0]       tid,
    output logic                   tid_valid,
    output logic [NUM_THREADS-1:0] grant_onehot
);

    logic [TID_W-1:0]       ptr_reg;
    logic [TID_W-1:0]       ptr_next;
    logic [TID_W-1:0]       tid_next;
    logic                   valid_next;
    logic [NUM_THREADS-1:0] onehot_next;
    logic [TID_W-1:0]       sel_grant;
    logic                   sel_found;

    rr_prio_select #(
        .NUM_REQ (NUM_THREADS),
        .IDX_W   (TID_W)
    ) u_select (
        .req   (thread_ready),
        .start (ptr_reg),
        .grant (sel_grant),
        .found (sel_found)
    );

    function automatic logic [TID_W-1:0] wrap_inc(input logic [TID_W-1:0] cur);
        return TID_W'(tid_wrap_inc(tid_t'(cur), NUM_THREADS));
    endfunction

    always_comb begin
        ptr_next   = ptr_reg;
        tid_next   = tid;
        valid_next = 1'b0;
        if (flush) begin
            ptr_next = '0;
            tid_next = '0;
        end else if (en) begin
            if (MODE == MODE_BARREL) begin
                // Slot belongs to ptr whether or not it is ready.
                tid_next   = ptr_reg;
                valid_next = thread_ready[ptr_reg];
                ptr_next   = wrap_inc(ptr_reg);
            end else if (sel_found) begin
                tid_next   = sel_grant;
                valid_next = 1'b1;
                ptr_next   = wrap_inc(sel_grant);
            end
        end
    end

    always_comb begin
        onehot_next = '0;
        if (valid_next) begin
            onehot_next[tid_next] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            tid          <= '0;
            tid_valid    <= 1'b0;
            grant_onehot <= '0;
        end else begin
            ptr_reg      <= ptr_next;
            tid          <= tid_next;
            tid_valid    <= valid_next;
            grant_onehot <= onehot_next;
        end
    end

endmodule

// File: tb/tb_thread_scheduler_rr.sv
// Bench for thread_scheduler_rr: three instances (4-thread RR, 3-thread RR,
// 4-thread barrel) checked each cycle against a behavioural model.
module tb_thread_scheduler_rr;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [3:0] ra;
    logic [2:0] rb;
    logic [3:0] rc;
    logic [1:0] tid_a, tid_b, tid_c;
    logic       val_a, val_b, val_c;
    logic [3:0] oh_a, oh_c;
    logic [2:0] oh_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_ptr[3];
    int m_tid[3];
    bit m_val[3];

    thread_scheduler_rr #(.NUM_THREADS(4), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .thread_ready(ra),
        .tid(tid_a), .tid_valid(val_a), .grant_onehot(oh_a));

    thread_scheduler_rr #(.NUM_THREADS(3), .MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .thread_ready(rb),
        .tid(tid_b), .tid_valid(val_b), .grant_onehot(oh_b));

    thread_scheduler_rr #(.NUM_THREADS(4), .MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .thread_ready(rc),
        .tid(tid_c), .tid_valid(val_c), .grant_onehot(oh_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_ptr[d] = 0;
            m_tid[d] = 0;
            m_val[d] = 1'b0;
        end
    endtask

    // Spec-level behaviour: search the ring from ptr, or take ptr outright.
    task automatic model_step(input int d, input int n, input int mode, input logic [3:0] rdy);
        int g;
        if (flush) begin
            m_ptr[d] = 0;
            m_tid[d] = 0;
            m_val[d] = 1'b0;
        end else if (!en) begin
            m_val[d] = 1'b0;
        end else if (mode == 1) begin
            m_tid[d] = m_ptr[d];
            m_val[d] = rdy[m_ptr[d]];
            m_ptr[d] = (m_ptr[d] + 1) % n;
        end else begin
            g = -1;
            for (int k = 0; k < n; k++) begin
                if (g < 0 && rdy[(m_ptr[d] + k) % n]) g = (m_ptr[d] + k) % n;
            end
            if (g >= 0) begin
                m_tid[d] = g;
                m_val[d] = 1'b1;
                m_ptr[d] = (g + 1) % n;
            end else begin
                m_val[d] = 1'b0;
            end
        end
    endtask

    function automatic int exp_oh(input int d);
        return m_val[d] ? (1 << m_tid[d]) : 0;
    endfunction

    task automatic compare_all();
        check("A.tid", int'(tid_a), m_tid[0]);
        check("A.valid", int'(val_a), int'(m_val[0]));
        check("A.onehot", int'(oh_a), exp_oh(0));
        check("B.tid", int'(tid_b), m_tid[1]);
        check("B.valid", int'(val_b), int'(m_val[1]));
        check("B.onehot", int'(oh_b), exp_oh(1));
        check("C.tid", int'(tid_c), m_tid[2]);
        check("C.valid", int'(val_c), int'(m_val[2]));
        check("C.onehot", int'(oh_c), exp_oh(2));
        $display("cyc=%0d en=%0b fl=%0b A:%0d/%0b B:%0d/%0b C:%0d/%0b",
                 cyc, en, flush, tid_a, val_a, tid_b, val_b, tid_c, val_c);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, 4, 0, ra);
        model_step(1, 3, 0, {1'b0, rb});
        model_step(2, 4, 1, rc);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".A.tid"}, int'(tid_a), 0);
        check({tag, ".A.valid"}, int'(val_a), 0);
        check({tag, ".A.onehot"}, int'(oh_a), 0);
        check({tag, ".B.onehot"}, int'(oh_b), 0);
        check({tag, ".C.tid"}, int'(tid_c), 0);
        check({tag, ".C.valid"}, int'(val_c), 0);
    endtask

    initial begin
        int exp_a_tid[6];
        int exp_a_oh[4];
        int exp_b_tid[4];
        int exp_c_val[4];
        int exp_b101[4];
        exp_a_tid = '{0, 1, 2, 3, 0, 1};
        exp_a_oh  = '{1, 2, 4, 8};
        exp_b_tid = '{0, 1, 2, 0};
        exp_c_val = '{1, 1, 0, 1};
        exp_b101  = '{0, 2, 0, 2};

        rst_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        ra    = '0;
        rb    = '0;
        rc    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // All ready from reset.
        en = 1'b1;
        ra = 4'b1111;
        rb = 3'b111;
        rc = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            check("lit.A.tid", int'(tid_a), exp_a_tid[i]);
            check("lit.A.valid", int'(val_a), 1);
            if (i < 4) begin
                check("lit.A.onehot", int'(oh_a), exp_a_oh[i]);
                check("lit.B.tid", int'(tid_b), exp_b_tid[i]);
                check("lit.C.tid", int'(tid_c), i);
                check("lit.C.valid", int'(val_c), exp_c_val[i]);
            end
        end

        // B with 3'b101; A grants 2, then idles with nothing ready.
        rb = 3'b101;
        for (int i = 0; i < 4; i++) begin
            ra = (i == 0) ? 4'b1111 : 4'b0000;
            step();
            check("lit.B101.tid", int'(tid_b), exp_b101[i]);
            check("lit.Aidle.tid", int'(tid_a), 2);
            check("lit.Aidle.valid", int'(val_a), (i == 0) ? 1 : 0);
        end
        ra = 4'b1111;
        step();
        check("lit.Aresume.tid", int'(tid_a), 3);
        check("lit.Aresume.valid", int'(val_a), 1);

        step();
        step();
        check("lit.Apre.tid", int'(tid_a), 1);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("lit.Astall.tid", int'(tid_a), 1);
            check("lit.Astall.valid", int'(val_a), 0);
        end
        en = 1'b1;
        step();
        check("lit.Aen.tid", int'(tid_a), 2);
        flush = 1'b1;
        step();
        check("lit.Aflush.tid", int'(tid_a), 0);
        check("lit.Aflush.valid", int'(val_a), 0);
        flush = 1'b0;
        step();
        check("lit.Apostflush.tid", int'(tid_a), 0);
        check("lit.Apostflush.valid", int'(val_a), 1);
        step();

        // Asynchronous reset between edges, mid-rotation.
        #2 rst_n = 1'b0;
        #1 check_all_zero("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rc = 4'b1111;
        step();
        check("lit.postrst.A.tid", int'(tid_a), 0);
        check("lit.postrst.A.valid", int'(val_a), 1);
        check("lit.postrst.C.tid", int'(tid_c), 0);

        // Randomised phase.
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) begin
                ra = 4'($urandom & $urandom);
                rb = 3'($urandom & $urandom);
                rc = 4'($urandom & $urandom);
            end else begin
                ra = 4'($urandom);
                rb = 3'($urandom);
                rc = 4'($urandom);
            end
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("rand.async");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
